// File: rtl/fft_stream_ctrl_pkg.sv
// Shared types and config-word layout for the streaming FFT control front-end.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      CFG,
      IDLE,
      FRAME
   } state_t;

   localparam int NFFT_LSB  = 0;
   localparam int INV_BIT   = 8;
   localparam int SCALE_LSB = 9;

   // Caller slices the result down to the core's config width.
   function automatic logic [63:0] pack_cfg(input logic [7:0]  nfft,
                                            input logic        inv,
                                            input logic [31:0] scale);
      pack_cfg = (64'(scale) << SCALE_LSB) | (64'(inv) << INV_BIT) | (64'(nfft) << NFFT_LSB);
   endfunction

endpackage

// File: rtl/fft_stream_ctrl_if.sv
// Valid/ready stream bundle used for every channel of the FFT front-end.
interface fft_stream_ctrl_if #(parameter int DW = 32);

   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/fft_stream_ctrl_frame_counter.sv
// Beat counter with programmable terminal count; wraps on terminal or forced wrap.
module fft_frame_counter #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_beat,
   input  logic         i_wrap,
   input  logic [W-1:0] i_term,
   output logic [W-1:0] o_count,
   output logic         o_last,
   output logic         o_done
);

   logic [W-1:0] r_count;

   assign o_count = r_count;
   assign o_last  = (r_count == i_term);
   assign o_done  = i_beat & (o_last | i_wrap);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (o_done) begin
         r_count <= '0;
      end else if (i_beat) begin
         r_count <= r_count + W'(1);
      end
   end

endmodule

// File: rtl/fft_stream_ctrl.sv
// Control front-end for the streaming FFT core: config channel, input tlast
// generation, output bin indexing, frame counters and output length checking.
module fft_stream_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = 32,
   parameter int DATA_OUT_WIDTH = 48,
   parameter int NFFT_MIN_LOG2  = 3,
   parameter int NFFT_MAX_LOG2  = 12,
   parameter int SCALE_WIDTH    = 12,
   parameter int CFG_WIDTH      = 24,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               cfg_nfft_log2,
   input  logic                     cfg_inverse,
   input  logic [SCALE_WIDTH-1:0]   cfg_scale,
   input  logic                     cfg_req,
   output logic                     cfg_busy,
   output logic                     rst_done,
   fft_stream_ctrl_if.slave         s_data,
   fft_stream_ctrl_if.master        core_cfg,
   fft_stream_ctrl_if.master        core_din,
   fft_stream_ctrl_if.slave         core_dout,
   fft_stream_ctrl_if.master        m_data,
   output logic [NFFT_MAX_LOG2-1:0] m_data_index,
   output logic [CNT_WIDTH-1:0]     frames_in,
   output logic [CNT_WIDTH-1:0]     frames_out,
   output logic                     len_err
);

   state_t                   r_state;
   logic                     r_cfg_valid;
   logic                     r_rst_done;
   logic                     r_pend;
   logic [4:0]               r_pend_nfft;
   logic                     r_pend_inv;
   logic [SCALE_WIDTH-1:0]   r_pend_scale;
   logic [4:0]               r_nfft;
   logic                     r_inv;
   logic [SCALE_WIDTH-1:0]   r_scale;
   logic [CNT_WIDTH-1:0]     r_frames_in;
   logic [CNT_WIDTH-1:0]     r_frames_out;
   logic                     r_len_err;

   logic [4:0]               w_req_nfft;
   logic [NFFT_MAX_LOG2-1:0] w_term;
   logic                     w_apply;
   logic                     w_en;
   logic                     w_in_beat;
   logic                     w_in_last;
   logic                     w_in_done;
   logic [NFFT_MAX_LOG2-1:0] w_in_count;
   logic                     w_out_beat;
   logic                     w_out_last;
   logic                     w_out_done;
   logic [63:0]              w_cfg_word;
   logic [DATA_IN_WIDTH-1:0] w_din;
   logic [DATA_OUT_WIDTH-1:0] w_dout;
   logic                     w_unused;

   always_comb begin
      w_req_nfft = cfg_nfft_log2;
      if (cfg_nfft_log2 < 5'(NFFT_MIN_LOG2)) begin
         w_req_nfft = 5'(NFFT_MIN_LOG2);
      end else if (cfg_nfft_log2 > 5'(NFFT_MAX_LOG2)) begin
         w_req_nfft = 5'(NFFT_MAX_LOG2);
      end
   end

   assign w_term     = ~({NFFT_MAX_LOG2{1'b1}} << r_nfft);
   // A pending config is only applied once every input frame has come back out.
   assign w_apply    = (r_state == IDLE) && r_pend && (r_frames_in == r_frames_out);
   assign w_en       = ((r_state == IDLE) && !w_apply) || (r_state == FRAME);
   assign w_in_beat  = s_data.tvalid & core_din.tready & w_en;
   assign w_out_beat = core_dout.tvalid & m_data.tready;

   assign w_cfg_word     = pack_cfg(8'(r_nfft), r_inv, 32'(r_scale));
   assign core_cfg.tdata  = w_cfg_word[CFG_WIDTH-1:0];
   assign core_cfg.tvalid = r_cfg_valid;
   assign core_cfg.tlast  = 1'b0;

   assign w_din           = s_data.tdata;
   assign core_din.tdata  = w_din;
   assign core_din.tvalid = s_data.tvalid & w_en;
   assign core_din.tlast  = w_in_last;
   assign s_data.tready   = core_din.tready & w_en;

   assign w_dout           = core_dout.tdata;
   assign m_data.tdata     = w_dout;
   assign m_data.tvalid    = core_dout.tvalid;
   assign m_data.tlast     = core_dout.tlast;
   assign core_dout.tready = m_data.tready;

   assign cfg_busy   = r_pend | (r_state == CFG);
   assign rst_done   = r_rst_done;
   assign frames_in  = r_frames_in;
   assign frames_out = r_frames_out;
   assign len_err    = r_len_err;

   assign w_unused = &{1'b0, s_data.tlast, w_cfg_word[63:CFG_WIDTH], w_in_count, w_out_done};

   fft_frame_counter #(.W(NFFT_MAX_LOG2)) u_in_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_beat  (w_in_beat),
      .i_wrap  (1'b0),
      .i_term  (w_term),
      .o_count (w_in_count),
      .o_last  (w_in_last),
      .o_done  (w_in_done)
   );

   fft_frame_counter #(.W(NFFT_MAX_LOG2)) u_out_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_beat  (w_out_beat),
      .i_wrap  (core_dout.tlast),
      .i_term  (w_term),
      .o_count (m_data_index),
      .o_last  (w_out_last),
      .o_done  (w_out_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= CFG;
         r_cfg_valid  <= 1'b0;
         r_rst_done   <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_nfft  <= '0;
         r_pend_inv   <= 1'b0;
         r_pend_scale <= '0;
         r_nfft       <= 5'(NFFT_MAX_LOG2);
         r_inv        <= 1'b0;
         r_scale      <= '0;
         r_frames_in  <= '0;
         r_frames_out <= '0;
         r_len_err    <= 1'b0;
      end else begin
         case (r_state)
            CFG: begin
               if (r_cfg_valid && core_cfg.tready) begin
                  r_cfg_valid <= 1'b0;
                  r_rst_done  <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_cfg_valid <= 1'b1;
               end
            end
            IDLE: begin
               if (w_apply) begin
                  r_nfft      <= r_pend_nfft;
                  r_inv       <= r_pend_inv;
                  r_scale     <= r_pend_scale;
                  r_pend      <= 1'b0;
                  r_cfg_valid <= 1'b1;
                  r_state     <= CFG;
               end else if (s_data.tvalid) begin
                  r_state <= FRAME;
               end
            end
            FRAME: begin
               if (w_in_done) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= CFG;
         endcase

         // Placed after the apply so a request in the same cycle stays pending.
         if (cfg_req) begin
            r_pend       <= 1'b1;
            r_pend_nfft  <= w_req_nfft;
            r_pend_inv   <= cfg_inverse;
            r_pend_scale <= cfg_scale;
         end

         if (w_in_done) begin
            r_frames_in <= r_frames_in + CNT_WIDTH'(1);
         end
         if (w_out_beat && core_dout.tlast) begin
            r_frames_out <= r_frames_out + CNT_WIDTH'(1);
         end
         if (w_out_beat && (core_dout.tlast != w_out_last)) begin
            r_len_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Self-checking bench for fft_stream_ctrl: config table, framing model, backpressure, reset.
module tb_fft_stream_ctrl;

   localparam int DIW = 32;
   localparam int DOW = 48;
   localparam int MINL = 3;
   localparam int MAXL = 12;
   localparam int SW = 12;
   localparam int CW = 24;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    cfg_nfft_log2;
   logic          cfg_inverse;
   logic [SW-1:0] cfg_scale;
   logic          cfg_req;
   logic          cfg_busy;
   logic          rst_done;
   logic [MAXL-1:0] m_data_index;
   logic [NW-1:0] frames_in;
   logic [NW-1:0] frames_out;
   logic          len_err;

   fft_stream_ctrl_if #(.DW(DIW)) s_data ();
   fft_stream_ctrl_if #(.DW(CW))  core_cfg ();
   fft_stream_ctrl_if #(.DW(DIW)) core_din ();
   fft_stream_ctrl_if #(.DW(DOW)) core_dout ();
   fft_stream_ctrl_if #(.DW(DOW)) m_data ();

   fft_stream_ctrl #(
      .DATA_IN_WIDTH (DIW),
      .DATA_OUT_WIDTH(DOW),
      .NFFT_MIN_LOG2 (MINL),
      .NFFT_MAX_LOG2 (MAXL),
      .SCALE_WIDTH   (SW),
      .CFG_WIDTH     (CW),
      .CNT_WIDTH     (NW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_nfft_log2(cfg_nfft_log2),
      .cfg_inverse  (cfg_inverse),
      .cfg_scale    (cfg_scale),
      .cfg_req      (cfg_req),
      .cfg_busy     (cfg_busy),
      .rst_done     (rst_done),
      .s_data       (s_data),
      .core_cfg     (core_cfg),
      .core_din     (core_din),
      .core_dout    (core_dout),
      .m_data       (m_data),
      .m_data_index (m_data_index),
      .frames_in    (frames_in),
      .frames_out   (frames_out),
      .len_err      (len_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state, kept in plain integers.
   int model_nfft;
   int in_pos;
   int out_idx;
   int model_frames_in;
   int model_frames_out;
   bit model_err;

   typedef struct {
      logic [4:0]    nfft;
      logic          inv;
      logic [SW-1:0] scale;
      logic [CW-1:0] word;
   } cfg_vec_t;

   cfg_vec_t vecs [7];

   function automatic int clampn(input int n);
      if (n < MINL) return MINL;
      if (n > MAXL) return MAXL;
      return n;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      model_nfft       = MAXL;
      in_pos           = 0;
      out_idx          = 0;
      model_frames_in  = 0;
      model_frames_out = 0;
      model_err        = 1'b0;
   endtask

   task automatic check_reset_values();
      check("rst_cfg_tvalid", core_cfg.tvalid, 1'b0);
      check("rst_rst_done", rst_done, 1'b0);
      check("rst_cfg_busy", cfg_busy, 1'b1);
      check("rst_s_tready", s_data.tready, 1'b0);
      check("rst_frames_in", frames_in, 0);
      check("rst_frames_out", frames_out, 0);
      check("rst_index", m_data_index, 0);
      check("rst_len_err", len_err, 1'b0);
   endtask

   task automatic pulse_req(input int n, input logic inv, input logic [SW-1:0] sc);
      s_data.tvalid = 1'b0;
      cfg_nfft_log2 = 5'(n);
      cfg_inverse   = inv;
      cfg_scale     = sc;
      cfg_req       = 1'b1;
      tick();
      cfg_req = 1'b0;
      check("req_busy", cfg_busy, 1'b1);
   endtask

   task automatic accept_cfg(input logic [CW-1:0] exp_word);
      int cyc;
      cyc = 0;
      while (!core_cfg.tvalid && cyc < 64) begin
         tick();
         cyc++;
      end
      check("cfg_valid_seen", core_cfg.tvalid, 1'b1);
      check("cfg_word", core_cfg.tdata, exp_word);
      check("cfg_busy_during", cfg_busy, 1'b1);
      check("cfg_s_tready_off", s_data.tready, 1'b0);
      core_cfg.tready = 1'b1;
      tick();
      core_cfg.tready = 1'b0;
      check("cfg_rst_done", rst_done, 1'b1);
      check("cfg_busy_after", cfg_busy, 1'b0);
      check("cfg_valid_after", core_cfg.tvalid, 1'b0);
      in_pos = 0;
   endtask

   task automatic send_input(input int n, input int pct);
      int acc;
      int cyc;
      int flen;
      acc  = 0;
      cyc  = 0;
      flen = 1 << model_nfft;
      while (acc < n && cyc < 4000) begin
         s_data.tvalid   = (pct >= 100) ? 1'b1 : ($urandom_range(99) < 80);
         s_data.tdata    = $urandom;
         core_din.tready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         #1;
         if (s_data.tready && !core_din.tready) check("din_ready_leak", s_data.tready, 1'b0);
         if (s_data.tready && s_data.tvalid) begin
            check("din_tvalid", core_din.tvalid, 1'b1);
            check("din_tdata", core_din.tdata, s_data.tdata);
            check("din_tlast", core_din.tlast, (in_pos == flen - 1));
            acc++;
            if (in_pos == flen - 1) begin
               in_pos = 0;
               model_frames_in++;
            end else begin
               in_pos++;
            end
         end
         tick();
         cyc++;
      end
      s_data.tvalid   = 1'b0;
      core_din.tready = 1'b1;
      check("din_beats_done", acc, n);
      check("frames_in", frames_in, NW'(model_frames_in));
   endtask

   task automatic send_output(input int n, input int tlast_at, input int pct);
      int acc;
      int cyc;
      int term;
      bit at_term;
      acc  = 0;
      cyc  = 0;
      term = (1 << model_nfft) - 1;
      while (acc < n && cyc < 4000) begin
         core_dout.tvalid = 1'b1;
         core_dout.tdata  = {16'($urandom), $urandom};
         core_dout.tlast  = (acc == tlast_at);
         m_data.tready    = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
         #1;
         check("dout_tready", core_dout.tready, m_data.tready);
         if (m_data.tready) begin
            check("m_tvalid", m_data.tvalid, 1'b1);
            check("m_tdata", m_data.tdata, core_dout.tdata);
            check("m_tlast", m_data.tlast, core_dout.tlast);
            check("m_index", m_data_index, MAXL'(out_idx));
            at_term = (out_idx == term);
            if (core_dout.tlast != at_term) model_err = 1'b1;
            if (core_dout.tlast) model_frames_out++;
            out_idx = (core_dout.tlast || at_term) ? 0 : out_idx + 1;
            acc++;
         end
         tick();
         cyc++;
      end
      core_dout.tvalid = 1'b0;
      core_dout.tlast  = 1'b0;
      m_data.tready    = 1'b1;
      check("dout_beats_done", acc, n);
      check("frames_out", frames_out, NW'(model_frames_out));
      check("len_err", len_err, model_err);
      check("m_index_idle", m_data_index, MAXL'(out_idx));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{nfft: 5'd2,  inv: 1'b0, scale: 12'h000, word: 24'h000003};
      vecs[1] = '{nfft: 5'd15, inv: 1'b0, scale: 12'h000, word: 24'h00000C};
      vecs[2] = '{nfft: 5'd31, inv: 1'b0, scale: 12'h800, word: 24'h10000C};
      vecs[3] = '{nfft: 5'd7,  inv: 1'b1, scale: 12'hFFF, word: 24'h1FFF07};
      vecs[4] = '{nfft: 5'd3,  inv: 1'b0, scale: 12'h123, word: 24'h024603};
      vecs[5] = '{nfft: 5'd12, inv: 1'b1, scale: 12'h001, word: 24'h00030C};
      vecs[6] = '{nfft: 5'd4,  inv: 1'b1, scale: 12'hAA5, word: 24'h154B04};

      rst              = 1'b1;
      cfg_nfft_log2    = '0;
      cfg_inverse      = 1'b0;
      cfg_scale        = '0;
      cfg_req          = 1'b0;
      s_data.tdata     = '0;
      s_data.tvalid    = 1'b0;
      s_data.tlast     = 1'b0;
      core_cfg.tready  = 1'b0;
      core_din.tready  = 1'b1;
      core_dout.tdata  = '0;
      core_dout.tvalid = 1'b0;
      core_dout.tlast  = 1'b0;
      m_data.tready    = 1'b1;
      model_reset();

      repeat (3) tick();
      check_reset_values();
      rst = 1'b0;
      accept_cfg(24'h00000C);

      // Config table: clamping and field packing.
      for (int i = 0; i < 7; i++) begin
         pulse_req(int'(vecs[i].nfft), vecs[i].inv, vecs[i].scale);
         accept_cfg(vecs[i].word);
         model_nfft = clampn(int'(vecs[i].nfft));
      end

      // Two continuous 16-point input frames, then their output frames.
      send_input(32, 100);
      send_output(16, 15, 100);
      send_output(16, 15, 100);

      // Request mid-frame: held until the frame ends and the output drains.
      send_input(5, 100);
      pulse_req(3, 1'b0, 12'h000);
      check("pend_no_cfg_mid", core_cfg.tvalid, 1'b0);
      send_input(11, 100);
      repeat (4) tick();
      check("pend_no_cfg_undrained", core_cfg.tvalid, 1'b0);
      check("pend_busy", cfg_busy, 1'b1);
      send_output(16, 15, 100);
      accept_cfg(24'h000003);
      model_nfft = 3;
      send_input(8, 100);
      send_output(8, 7, 100);

      // Random backpressure on both sides.
      send_input(24, 50);
      for (int f = 0; f < 3; f++) send_output(8, 7, 50);

      // Output length errors: early tlast, then missing tlast; sticky flag.
      send_output(6, 5, 100);
      send_output(8, 7, 100);
      send_output(10, -1, 100);

      // Reset mid-frame.
      send_input(3, 100);
      s_data.tvalid = 1'b1;
      rst = 1'b1;
      tick();
      check_reset_values();
      rst = 1'b0;
      s_data.tvalid = 1'b0;
      model_reset();
      accept_cfg(24'h00000C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
